// File: rtl/cs_acq_ctrl_if.sv
// Handshake bundle between cs_acq_ctrl and its neighbours.
//   cmd_* : command decoder link (kdev mask, start fs, finish fd, err, busy)
//   num_* : cs_num link (fs/fd plus the two returned lengths)
//   adc_* : ADC engine link (fs/fd, device index, receive length)
//   eth_* : Ethernet engine link (fs/fd, transmit length)
// master = the sequencer, slave = the surrounding engines/decoder.
interface cs_acq_ctrl_if #(
  parameter int KDEV_W = 8
);
  localparam int DEV_W = $clog2(KDEV_W);

  logic [KDEV_W-1:0] cmd_kdev;
  logic              cmd_fs;
  logic              cmd_fd;
  logic              err;
  logic              busy;
  logic              num_fs;
  logic              num_fd;
  logic [9:0]        num_adc_len;
  logic [11:0]       num_eth_len;
  logic              adc_fs;
  logic              adc_fd;
  logic [DEV_W-1:0]  adc_dev;
  logic [9:0]        adc_len;
  logic              eth_fs;
  logic              eth_fd;
  logic [11:0]       eth_len;

  modport master (
    input  cmd_kdev, cmd_fs, num_fd, num_adc_len, num_eth_len, adc_fd, eth_fd,
    output cmd_fd, err, busy, num_fs, adc_fs, adc_dev, adc_len, eth_fs, eth_len
  );

  modport slave (
    output cmd_kdev, cmd_fs, num_fd, num_adc_len, num_eth_len, adc_fd, eth_fd,
    input  cmd_fd, err, busy, num_fs, adc_fs, adc_dev, adc_len, eth_fs, eth_len
  );
endinterface

// File: rtl/cs_acq_ctrl.sv
// Acquisition-cycle sequencer. On a start it latches the device mask, fetches
// ADC/Ethernet lengths from cs_num, reads every enabled device in ascending
// index order, sends one Ethernet frame and reports done. Every wait state is
// guarded by a timeout that lands in ERR.
//   clk, rst : clock, synchronous active-high reset
//   bus      : cs_acq_ctrl_if.master (all handshake / data signals)
// All outputs are registered.
module cs_acq_ctrl #(
  parameter int KDEV_W  = 8,
  parameter int TMO_CYC = 65535
) (
  input  logic           clk,
  input  logic           rst,
  cs_acq_ctrl_if.master  bus
);
  localparam int          DEV_W    = $clog2(KDEV_W);
  localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);

  typedef enum logic [3:0] {
    IDLE, NUM, NUM_REL, SCAN, ADC, ADC_REL, ETH, ETH_REL, DONE, ERR
  } state_e;

  state_e             state_q, state_d;
  logic [KDEV_W-1:0]  mask_q, mask_d;
  logic [DEV_W-1:0]   adc_dev_q, adc_dev_d, low_idx;
  logic [9:0]         adc_len_q, adc_len_d;
  logic [11:0]        eth_len_q, eth_len_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               cmd_fd_q, cmd_fd_d;
  logic               busy_q, busy_d;
  logic               num_fs_q, num_fs_d;
  logic               adc_fs_q, adc_fs_d;
  logic               eth_fs_q, eth_fs_d;
  logic               wait_st;

  // Lowest set bit of the working mask; scanning downward lets the lowest win.
  always_comb begin
    low_idx = '0;
    for (int i = KDEV_W - 1; i >= 0; i--)
      if (mask_q[i]) low_idx = DEV_W'(i);
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    adc_dev_d = adc_dev_q;
    adc_len_d = adc_len_q;
    eth_len_d = eth_len_q;
    err_d     = err_q;
    wait_st   = state_q inside {NUM, NUM_REL, ADC, ADC_REL, ETH, ETH_REL};

    unique case (state_q)
      IDLE: if (bus.cmd_fs) begin
        mask_d  = bus.cmd_kdev;
        err_d   = 1'b0;
        state_d = (bus.cmd_kdev == '0) ? DONE : NUM;
      end
      NUM: if (bus.num_fd) begin
        adc_len_d = bus.num_adc_len;
        eth_len_d = bus.num_eth_len;
        state_d   = NUM_REL;
      end
      NUM_REL: if (!bus.num_fd) state_d = SCAN;
      SCAN: if (mask_q == '0) state_d = ETH;
            else begin
              adc_dev_d = low_idx;
              state_d   = ADC;
            end
      ADC: if (bus.adc_fd) begin
        mask_d[adc_dev_q] = 1'b0;
        state_d           = ADC_REL;
      end
      ADC_REL: if (!bus.adc_fd) state_d = SCAN;
      ETH:     if (bus.eth_fd)  state_d = ETH_REL;
      ETH_REL: if (!bus.eth_fd) state_d = DONE;
      DONE, ERR: if (!bus.cmd_fs) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A handshake completing on the last allowed cycle still wins.
    if (wait_st && state_d == state_q && cnt_q == TMO_LAST) state_d = ERR;
    if (state_d == ERR) err_d = 1'b1;

    cnt_d = (state_d != state_q || !wait_st) ? 16'd0 : cnt_q + 16'd1;

    // fs/busy look at the next state so they move on the same edge as the FSM.
    num_fs_d = (state_d == NUM);
    adc_fs_d = (state_d == ADC);
    eth_fs_d = (state_d == ETH);
    busy_d   = (state_d != IDLE);
    // cmd_fd rises one edge after DONE/ERR is reached and falls on the edge
    // that sees cmd_fs low.
    cmd_fd_d = (state_q inside {DONE, ERR}) && bus.cmd_fs;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      adc_dev_q <= '0;
      adc_len_q <= '0;
      eth_len_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      cmd_fd_q  <= 1'b0;
      busy_q    <= 1'b0;
      num_fs_q  <= 1'b0;
      adc_fs_q  <= 1'b0;
      eth_fs_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      adc_dev_q <= adc_dev_d;
      adc_len_q <= adc_len_d;
      eth_len_q <= eth_len_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      cmd_fd_q  <= cmd_fd_d;
      busy_q    <= busy_d;
      num_fs_q  <= num_fs_d;
      adc_fs_q  <= adc_fs_d;
      eth_fs_q  <= eth_fs_d;
    end
  end

  assign bus.cmd_fd  = cmd_fd_q;
  assign bus.err     = err_q;
  assign bus.busy    = busy_q;
  assign bus.num_fs  = num_fs_q;
  assign bus.adc_fs  = adc_fs_q;
  assign bus.adc_dev = adc_dev_q;
  assign bus.adc_len = adc_len_q;
  assign bus.eth_fs  = eth_fs_q;
  assign bus.eth_len = eth_len_q;
endmodule

// File: tb/tb_cs_acq_ctrl.sv
// Self-checking bench for cs_acq_ctrl (TMO_CYC=16). Behavioural responders for
// cs_num/ADC/Ethernet, a monitor logging fs rises, and a model that derives the
// expected device order from the latched mask.
module tb_cs_acq_ctrl;
  logic clk;
  logic rst;

  cs_acq_ctrl_if #(.KDEV_W(8)) ifc ();

  cs_acq_ctrl #(.KDEV_W(8), .TMO_CYC(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total, bad;
  int num_dly, adc_dly, eth_dly;
  bit adc_hang;
  int exp_adc_len, exp_eth_len;

  // monitor state
  int devq[$];
  int num_rises, eth_rises, adc_before_eth, dev_unstable;
  logic p_adc, p_num, p_eth;
  logic [2:0] p_dev;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sel_sig(input int s);
    case (s)
      0:       return ifc.cmd_fd;
      1:       return ifc.adc_fs;
      default: return ifc.eth_fs;
    endcase
  endfunction

  // Bounded wait at negedges for a DUT output to go high.
  task automatic wait_for(input string tag, input int s);
    int n = 0;
    while (sel_sig(s) !== 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    chk(tag, 32'(sel_sig(s)), 32'd1);
  endtask

  // Responders: fd rises dly+1 negedges after fs seen, drops once fs is low.
  initial begin
    int c = 0;
    ifc.num_fd = 1'b0;
    forever begin
      tick();
      if (ifc.num_fs) begin
        if (!ifc.num_fd) begin
          if (c >= num_dly) ifc.num_fd = 1'b1; else c++;
        end
      end else begin
        c = 0;
        ifc.num_fd = 1'b0;
      end
    end
  end

  initial begin
    int c = 0;
    ifc.adc_fd = 1'b0;
    forever begin
      tick();
      if (ifc.adc_fs) begin
        if (!ifc.adc_fd && !adc_hang) begin
          if (c >= adc_dly) ifc.adc_fd = 1'b1; else c++;
        end
      end else begin
        c = 0;
        ifc.adc_fd = 1'b0;
      end
    end
  end

  initial begin
    int c = 0;
    ifc.eth_fd = 1'b0;
    forever begin
      tick();
      if (ifc.eth_fs) begin
        if (!ifc.eth_fd) begin
          if (c >= eth_dly) ifc.eth_fd = 1'b1; else c++;
        end
      end else begin
        c = 0;
        ifc.eth_fd = 1'b0;
      end
    end
  end

  // Monitor: logs adc_dev on each adc_fs rise and counts num/eth requests.
  initial begin
    p_adc = 1'b0; p_num = 1'b0; p_eth = 1'b0; p_dev = '0;
    forever begin
      tick();
      if (ifc.adc_fs && !p_adc) devq.push_back(int'(ifc.adc_dev));
      if (ifc.adc_fs && p_adc && ifc.adc_dev != p_dev) dev_unstable++;
      if (ifc.num_fs && !p_num) num_rises++;
      if (ifc.eth_fs && !p_eth) begin
        eth_rises++;
        adc_before_eth = devq.size();
      end
      p_adc = ifc.adc_fs; p_num = ifc.num_fs; p_eth = ifc.eth_fs; p_dev = ifc.adc_dev;
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd_fd"},  32'(ifc.cmd_fd),  32'd0);
    chk({tag, "_err"},     32'(ifc.err),     32'd0);
    chk({tag, "_busy"},    32'(ifc.busy),    32'd0);
    chk({tag, "_num_fs"},  32'(ifc.num_fs),  32'd0);
    chk({tag, "_adc_fs"},  32'(ifc.adc_fs),  32'd0);
    chk({tag, "_eth_fs"},  32'(ifc.eth_fs),  32'd0);
    chk({tag, "_adc_dev"}, 32'(ifc.adc_dev), 32'd0);
    chk({tag, "_adc_len"}, 32'(ifc.adc_len), 32'd0);
    chk({tag, "_eth_len"}, 32'(ifc.eth_len), 32'd0);
  endtask

  // One full acquisition cycle; dly<0 picks random responder delays.
  task automatic run_cycle(input string tag, input logic [7:0] mask,
                           input logic [9:0] adl, input logic [11:0] ethl, input int dly);
    int exp_devs[$];
    num_dly = (dly < 0) ? int'($urandom_range(3)) : dly;
    adc_dly = (dly < 0) ? int'($urandom_range(3)) : dly;
    eth_dly = (dly < 0) ? int'($urandom_range(3)) : dly;
    ifc.num_adc_len = adl;
    ifc.num_eth_len = ethl;
    devq.delete();
    num_rises = 0; eth_rises = 0; dev_unstable = 0; adc_before_eth = -1;
    for (int i = 0; i < 8; i++) if (mask[i]) exp_devs.push_back(i);

    ifc.cmd_kdev = mask;
    ifc.cmd_fs   = 1'b1;
    tick();
    ifc.cmd_kdev = 8'($urandom);  // must be ignored from here on
    chk({tag, "_busy_after_start"}, 32'(ifc.busy), 32'd1);
    chk({tag, "_err_cleared"},      32'(ifc.err),  32'd0);
    if (mask == 8'h00) begin
      chk({tag, "_fd_not_early"}, 32'(ifc.cmd_fd), 32'd0);
      tick();
      chk({tag, "_fd_two_cycles"}, 32'(ifc.cmd_fd), 32'd1);
    end else begin
      wait_for({tag, "_cmd_fd_wait"}, 0);
      exp_adc_len = int'(adl);
      exp_eth_len = int'(ethl);
    end

    chk({tag, "_adc_count"}, 32'(devq.size()), 32'(exp_devs.size()));
    for (int k = 0; k < exp_devs.size() && k < devq.size(); k++)
      chk($sformatf("%s_dev%0d", tag, k), 32'(devq[k]), 32'(exp_devs[k]));
    chk({tag, "_num_rises"}, 32'(num_rises), 32'(mask != 0));
    chk({tag, "_eth_rises"}, 32'(eth_rises), 32'(mask != 0));
    if (mask != 0) chk({tag, "_eth_after_adc"}, 32'(adc_before_eth), 32'($countones(mask)));
    chk({tag, "_dev_stable"}, 32'(dev_unstable), 32'd0);
    chk({tag, "_adc_len"}, 32'(ifc.adc_len), 32'(exp_adc_len));
    chk({tag, "_eth_len"}, 32'(ifc.eth_len), 32'(exp_eth_len));
    chk({tag, "_err"}, 32'(ifc.err), 32'd0);
    chk({tag, "_fs_idle"}, 32'({ifc.num_fs, ifc.adc_fs, ifc.eth_fs}), 32'd0);

    ifc.cmd_fs = 1'b0;
    tick();
    chk({tag, "_fd_release"}, 32'(ifc.cmd_fd), 32'd0);
    chk({tag, "_busy_release"}, 32'(ifc.busy), 32'd0);
  endtask

  initial begin
    total = 0; bad = 0;
    num_dly = 1; adc_dly = 1; eth_dly = 1; adc_hang = 1'b0;
    exp_adc_len = 0; exp_eth_len = 0;
    num_rises = 0; eth_rises = 0; adc_before_eth = -1; dev_unstable = 0;
    rst = 1'b1;
    ifc.cmd_fs = 1'b0;
    ifc.cmd_kdev = '0;
    ifc.num_adc_len = '0;
    ifc.num_eth_len = '0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    run_cycle("basic", 8'h05, 10'd64, 12'd132, 1);
    run_cycle("empty", 8'h00, 10'd5, 12'd6, 1);
    run_cycle("full",  8'hFF, 10'($urandom_range(1023)), 12'($urandom_range(4095)), -1);
    for (int r = 0; r < 6; r++)
      run_cycle($sformatf("rnd%0d", r), 8'($urandom_range(255)),
                10'($urandom_range(1023)), 12'($urandom_range(4095)), -1);

    // Timeout: ADC engine never answers.
    adc_hang = 1'b1;
    num_dly = 0;
    ifc.num_adc_len = 10'd300;
    ifc.num_eth_len = 12'd900;
    ifc.cmd_kdev = 8'h10;
    ifc.cmd_fs = 1'b1;
    tick();
    wait_for("tmo_adc_fs_wait", 1);
    repeat (15) tick();
    chk("tmo_still_waiting", 32'(ifc.adc_fs), 32'd1);
    chk("tmo_no_err_yet", 32'(ifc.err), 32'd0);
    tick();
    chk("tmo_err", 32'(ifc.err), 32'd1);
    chk("tmo_adc_fs_low", 32'(ifc.adc_fs), 32'd0);
    chk("tmo_busy", 32'(ifc.busy), 32'd1);
    tick();
    chk("tmo_cmd_fd", 32'(ifc.cmd_fd), 32'd1);
    ifc.cmd_fs = 1'b0;
    tick();
    chk("tmo_fd_release", 32'(ifc.cmd_fd), 32'd0);
    chk("tmo_err_sticky", 32'(ifc.err), 32'd1);
    chk("tmo_idle", 32'(ifc.busy), 32'd0);
    adc_hang = 1'b0;
    exp_adc_len = 300; exp_eth_len = 900;
    tick();
    run_cycle("after_tmo", 8'h42, 10'd17, 12'd34, -1);

    // Reset while the Ethernet request is outstanding.
    eth_dly = 3;
    ifc.num_adc_len = 10'd77;
    ifc.num_eth_len = 12'd88;
    ifc.cmd_kdev = 8'h03;
    ifc.cmd_fs = 1'b1;
    tick();
    wait_for("rst_eth_fs_wait", 2);
    ifc.cmd_fs = 1'b0;
    rst = 1'b1;
    tick();
    chk_all_zero("rst_mid");
    rst = 1'b0;
    exp_adc_len = 0; exp_eth_len = 0;
    repeat (2) tick();
    run_cycle("after_rst", 8'hA5, 10'd511, 12'd2047, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
